cbb_rr_arb_mux: RTL and testbench
=================================

# cbb_rr_arb_mux

Round-robin, packet-aware arbiter that shares one WIDTH-bit output channel between N requesters. It generates a one-hot select, routes the winner's data through a one-hot mux into a single registered output stage, and keeps the grant locked on one requester until that requester's packet ends. It sits in front of any shared downstream resource in the sort datapath, such as a merge stage input or a result collector, that several producers feed.

## Interface

Parameters:

- WIDTH, 8, data width per requester
- N, 4, number of requesters (N >= 2)

Ports:

- clk  input  1  clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  N  per-requester valid
- in_last  input  N  per-requester end-of-packet flag
- in_data  input  WIDTH*N  packed data; requester i occupies [WIDTH*i +: WIDTH]
- in_ready  output  N  per-requester ready; at most one bit set
- out_valid  output  1  output register holds a beat
- out_last  output  1  last flag of the held beat
- out_data  output  WIDTH  data of the held beat
- out_src  output  N  one-hot index of the requester that produced the held beat
- out_ready  input  1  downstream accepts the beat

## Operation

- Clock and reset: one clock; reset is synchronous and active-low.
- Load enable: `load = ~out_valid | out_ready`.
  - The output register takes a new beat only when `load` is high.
- State machine:
  - ARB: the winner is the first requester with in_valid=1, searching from ptr upward and wrapping modulo N.
  - LOCK: the winner is fixed to `owner` and is eligible only when in_valid[owner]=1.
- Grant:
  - `in_ready[i] = load & winner_onehot[i]`.
  - All other in_ready bits are 0.
  - in_ready never depends on in_data.
- Transfer: occurs when in_valid[i] & in_ready[i]. On a transfer:
  - out_data <= in_data slice i (selected with a one-hot mux)
  - out_last <= in_last[i]
  - out_src <= one-hot(i)
  - out_valid <= 1
- No transfer while load=1: out_valid <= 0. out_data, out_last and out_src hold their previous values.
- load=0: all output registers hold.
- Transitions:
  - ARB -> LOCK, owner <= i: on a transfer with in_last[i]=0.
  - ARB -> ARB: on a transfer with in_last[i]=1 (single-beat packet).
  - LOCK -> ARB: on a transfer from owner with in_last=1.
  - LOCK -> LOCK: in every other case, including when the owner is stalled.
- Pointer:
  - On every transfer made in ARB state, ptr <= (i+1) mod N.
  - ptr is unchanged while in LOCK.
- Owner stall in LOCK: no other requester is granted. The output drains and out_valid falls to 0 until the owner resumes.
- Reset values:
  - state=ARB, ptr=0, owner=0
  - out_valid=0, out_last=0, out_data=0, out_src=0
  - in_ready=0 while rst_n=0

## Timing

- Latency is 1 cycle from an input transfer to out_valid/out_data.
- Throughput is 1 beat per cycle with out_ready held at 1, including back-to-back beats from different requesters in ARB.
- Combinational paths:
  - out_ready -> in_ready
  - in_valid -> in_ready
- All other outputs are registered.
- Boundary conditions:
  - Pointer wrap: ptr=N-1 with requester N-1 winning sets ptr to 0.
  - Simultaneous out_ready and a new transfer in the same cycle: the output is replaced with no bubble, no loss and no duplication.
  - A single requester requesting continuously gets every cycle.
  - No requests: out_valid goes low after the held beat drains.
- Reset mid-packet:
  - The next edge with rst_n=0 returns the block to ARB with ptr=0 and clears out_valid.
  - The partial packet is abandoned; recovery is the upstream's responsibility.
  - While rst_n=0, in_ready=0 regardless of in_valid.

## Test plan

1. Reset: rst_n=0 for 2 cycles with in_valid=4'b1111.
   - During reset: in_ready=0, out_valid=0, out_data=0, out_src=0.
   - First cycle after release: in_ready=4'b0001.
2. Fairness: all 4 requesters valid, in_last=1, data 0x01/0x02/0x04/0x08 on requesters 0/1/2/3, out_ready=1.
   - out_data: 01,02,04,08,01,... one per cycle.
   - out_src: 0001,0010,0100,1000 repeating.
3. Backpressure: out_valid=1 with out_data=0x02, then out_ready=0 for 3 cycles.
   - out_data and out_src stay stable and in_ready=0 throughout.
   - After release, the next beat is 0x04 with no duplicates.
4. Packet lock: requester 1 sends 3 beats 0xA0,0xA1,0xA2 with in_last on the 3rd; requester 2 is valid throughout.
   - in_ready[2]=0 until 0xA2 transfers; requester 2's beat appears on the next cycle.
5. Owner stall: in the middle of requester 1's packet, in_valid[1]=0 for 2 cycles while requester 3 is valid.
   - out_valid drops to 0 and in_ready[3] stays 0.
   - The packet resumes when in_valid[1] returns to 1.
6. Wrap and reset mid-packet:
   - With ptr=3 and requesters 0 and 3 valid, requester 3 wins, then requester 0.
   - Assert rst_n=0 while locked; the next grant after release goes to requester 0.

Source files
------------

// File: rtl/cbb_rr_arb_mux.sv
// cbb_rr_arb_mux: round-robin, packet-aware N:1 arbiter with a one-hot data
// mux feeding a single registered output stage. The grant stays locked on a
// requester from its first beat until its last beat has been transferred.

module cbb_rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    input  logic [WIDTH*N-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic               out_last,
    output logic [WIDTH-1:0]   out_data,
    output logic [N-1:0]       out_src,
    input  logic               out_ready
);

    localparam int          PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU = N;

    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   owner_nxt;

    logic            load;
    logic            xfer;
    logic [N-1:0]    winner;
    logic [PW-1:0]   win_idx;
    logic            win_last;
    logic [WIDTH-1:0] mux_data;

    // The output register can accept a beat when empty or being drained.
    assign load = ~out_valid | out_ready;

    // A grant is only ever issued to a valid requester, so any ready bit is a transfer.
    assign xfer = |(in_valid & in_ready);

    // State register: arbitration mode, round-robin pointer and packet owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // Next state: lock on a multi-beat packet, unlock on its last beat, advance pointer in ARB.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (xfer) begin
            case (state)
                ARB: begin
                    ptr_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
                    if (!win_last) begin
                        state_nxt = LOCK;
                        owner_nxt = win_idx;
                    end
                end
                LOCK: begin
                    if (win_last) begin
                        state_nxt = ARB;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    // Output decode: pick the winner (rotating search in ARB, fixed owner in LOCK) and gate ready.
    always_comb begin
        int unsigned idx;
        logic        found;
        winner  = '0;
        win_idx = '0;
        idx     = 0;
        found   = 1'b0;
        if (state == LOCK) begin
            if (in_valid[owner]) begin
                winner[owner] = 1'b1;
                win_idx       = owner;
            end
        end else begin
            for (int unsigned k = 0; k < NU; k++) begin
                idx = ptr + k;
                if (idx >= NU) begin
                    idx = idx - NU;
                end
                if (!found && in_valid[idx[PW-1:0]]) begin
                    found                = 1'b1;
                    winner[idx[PW-1:0]]  = 1'b1;
                    win_idx              = idx[PW-1:0];
                end
            end
        end
        in_ready = (rst_n && load) ? winner : '0;
    end

    // One-hot data/last mux driven by the grant vector.
    always_comb begin
        mux_data = '0;
        win_last = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (in_ready[i]) begin
                mux_data = mux_data | in_data[WIDTH*i +: WIDTH];
                win_last = win_last | in_last[i];
            end
        end
    end

    // Output stage: capture on transfer, empty on an idle load, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_last  <= win_last;
                out_data  <= mux_data;
                out_src   <= in_ready;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cbb_rr_arb_mux.sv
// Testbench for cbb_rr_arb_mux: directed stimulus pushes hand-computed beats
// into a scoreboard queue; a monitor pops and compares each accepted beat.

module tb_cbb_rr_arb_mux;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] src;
        logic       last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [WIDTH*N-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic               out_last;
    logic [WIDTH-1:0]   out_data;
    logic [N-1:0]       out_src;
    logic               out_ready;

    beat_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    cbb_rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached, expected $finish");
        $fatal(1);
    end

    // Monitor: every beat the downstream accepts must match the scoreboard head.
    always @(negedge clk) begin
        beat_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL beat: got unexpected data=%h src=%b last=%b, expected none",
                         out_data, out_src, out_last);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_src !== e.src || out_last !== e.last) begin
                    n_err++;
                    $display("FAIL beat: got data=%h src=%b last=%b, expected data=%h src=%b last=%b",
                             out_data, out_src, out_last, e.data, e.src, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] s, input logic l);
        beat_t b;
        b.data = d;
        b.src  = s;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic l);
        in_data[WIDTH*i +: WIDTH] = d;
        in_last[i]                = l;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s drain: got %0d beats pending, expected 0", name, sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        logic [3:0] e;

        // Reset with all requesters valid.
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data   = {8'h08, 8'h04, 8'h02, 8'h01};
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_in_ready", 32'(in_ready), 32'h0);
            chk("reset_out_valid", 32'(out_valid), 32'h0);
            chk("reset_out_data", 32'(out_data), 32'h0);
            chk("reset_out_src", 32'(out_src), 32'h0);
        end
        tick();
        rst_n = 1'b1;

        // Fairness: single-beat packets from everyone rotate one per cycle.
        for (int k = 0; k < 8; k++) begin
            e = 4'b0001 << (k % 4);
            push(8'h01 << (k % 4), e, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = 4'b0001 << (k % 4);
            chk("fair_in_ready", 32'(in_ready), 32'(e));
            tick();
        end
        in_valid = 4'b0000;
        drain("fair");
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        tick();

        // Backpressure: hold 0x02 for 3 stalled cycles, then resume with 0x04.
        push(8'h01, 4'b0001, 1'b1);
        push(8'h02, 4'b0010, 1'b1);
        push(8'h04, 4'b0100, 1'b1);
        push(8'h08, 4'b1000, 1'b1);
        in_valid = 4'b1111;
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_data", 32'(out_data), 32'h02);
            chk("bp_out_src", 32'(out_src), 32'b0010);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_in_ready", 32'(in_ready), 32'b0100);
        tick();
        tick();
        in_valid = 4'b0000;
        drain("backpressure");

        // Packet lock: requester 1 holds the grant until its last beat.
        in_valid = 4'b0110;
        set_req(1, 8'hA0, 1'b0);
        set_req(2, 8'hB0, 1'b1);
        push(8'hA0, 4'b0010, 1'b0);
        push(8'hA1, 4'b0010, 1'b0);
        push(8'hA2, 4'b0010, 1'b1);
        push(8'hB0, 4'b0100, 1'b1);
        @(negedge clk);
        chk("lock_in_ready0", 32'(in_ready), 32'b0010);
        tick();
        set_req(1, 8'hA1, 1'b0);
        @(negedge clk);
        chk("lock_in_ready1", 32'(in_ready), 32'b0010);
        tick();
        set_req(1, 8'hA2, 1'b1);
        @(negedge clk);
        chk("lock_in_ready2", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b0100;
        @(negedge clk);
        chk("lock_release_in_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = 4'b0000;
        drain("lock");

        // Owner stall: requester 3 must not be granted while owner 1 pauses.
        in_valid = 4'b0010;
        set_req(1, 8'hC0, 1'b0);
        set_req(3, 8'hD0, 1'b1);
        push(8'hC0, 4'b0010, 1'b0);
        push(8'hC1, 4'b0010, 1'b0);
        push(8'hC2, 4'b0010, 1'b1);
        push(8'hD0, 4'b1000, 1'b1);
        @(negedge clk);
        chk("stall_start_in_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b1000;
        @(negedge clk);
        chk("stall_in_ready_a", 32'(in_ready), 32'h0);
        chk("stall_out_valid_a", 32'(out_valid), 32'h1);
        tick();
        @(negedge clk);
        chk("stall_in_ready_b", 32'(in_ready), 32'h0);
        chk("stall_out_valid_b", 32'(out_valid), 32'h0);
        tick();
        in_valid = 4'b1010;
        set_req(1, 8'hC1, 1'b0);
        @(negedge clk);
        chk("stall_resume_in_ready", 32'(in_ready), 32'b0010);
        tick();
        set_req(1, 8'hC2, 1'b1);
        @(negedge clk);
        chk("stall_last_in_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b1000;
        @(negedge clk);
        chk("stall_after_in_ready", 32'(in_ready), 32'b1000);
        tick();
        in_valid = 4'b0000;
        drain("stall");

        // Pointer wrap: move ptr to 3, then requester 3 wins before requester 0.
        in_valid = 4'b0100;
        set_req(2, 8'hE0, 1'b1);
        push(8'hE0, 4'b0100, 1'b1);
        @(negedge clk);
        chk("wrap_setup_in_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = 4'b1001;
        set_req(0, 8'hF0, 1'b1);
        set_req(3, 8'hF3, 1'b1);
        push(8'hF3, 4'b1000, 1'b1);
        push(8'hF0, 4'b0001, 1'b1);
        @(negedge clk);
        chk("wrap_in_ready3", 32'(in_ready), 32'b1000);
        tick();
        @(negedge clk);
        chk("wrap_in_ready0", 32'(in_ready), 32'b0001);
        tick();

        // Reset mid-packet: lock on requester 2, then reset; grant restarts at 0.
        in_valid = 4'b0100;
        set_req(2, 8'h60, 1'b0);
        push(8'h60, 4'b0100, 1'b0);
        @(negedge clk);
        chk("midrst_lock_in_ready", 32'(in_ready), 32'b0100);
        tick();
        rst_n    = 1'b0;
        in_valid = 4'b1101;
        set_req(0, 8'h70, 1'b1);
        set_req(2, 8'h61, 1'b0);
        set_req(3, 8'h73, 1'b1);
        @(negedge clk);
        chk("midrst_in_ready_a", 32'(in_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("midrst_in_ready_b", 32'(in_ready), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_src", 32'(out_src), 32'h0);
        tick();
        rst_n = 1'b1;
        push(8'h70, 4'b0001, 1'b1);
        @(negedge clk);
        chk("midrst_release_in_ready", 32'(in_ready), 32'b0001);
        tick();
        in_valid = 4'b0000;
        drain("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
